// File: rtl/ula_seq_pkg.sv
// rtl/ula_seq_pkg.sv - shared types and field constants for the ALU sequencer
package ula_seq_pkg;

    localparam int ULA_DATA_W = 16;
    localparam int ULA_NREG   = 8;
    localparam int REG_W      = $clog2(ULA_NREG);

    // Instruction field positions
    localparam int OP_LSB = 12;
    localparam int OP_W   = 4;
    localparam int RX_LSB = 9;
    localparam int RY_LSB = 6;

    localparam logic [OP_W-1:0] OP_MV  = 4'b0000;
    localparam logic [OP_W-1:0] OP_MVI = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SLT = 4'b0101;
    localparam logic [OP_W-1:0] OP_SLL = 4'b0110;
    localparam logic [OP_W-1:0] OP_SRL = 4'b0111;

    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_OR  = 3'b010;
    localparam logic [2:0] ULA_SLT = 3'b011;
    localparam logic [2:0] ULA_SLL = 3'b100;
    localparam logic [2:0] ULA_SRL = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

endpackage

// File: rtl/ula_seq_decode.sv
// rtl/ula_seq_decode.sv - combinational instruction decoder for the ALU sequencer
module ula_seq_decode
    import ula_seq_pkg::*;
#(
    parameter int DATA_W = ULA_DATA_W,
    parameter int NREG   = ULA_NREG
) (
    input  logic [DATA_W-1:0] ir,
    output logic              is_mv,
    output logic              is_mvi,
    output logic              is_alu,
    output logic              is_illegal,
    output logic [2:0]        ula_op,
    output logic [NREG-1:0]   rx_oh,
    output logic [NREG-1:0]   ry_oh
);

    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rx;
    logic [REG_W-1:0] ry;
    logic             unused_ir_low;

    assign op = ir[OP_LSB +: OP_W];
    assign rx = ir[RX_LSB +: REG_W];
    assign ry = ir[RY_LSB +: REG_W];

    // The low instruction bits carry no meaning for this machine
    assign unused_ir_low = ^ir[RY_LSB-1:0];

    assign rx_oh = {{(NREG-1){1'b0}}, 1'b1} << rx;
    assign ry_oh = {{(NREG-1){1'b0}}, 1'b1} << ry;

    // Opcode classification and ALU select; anything with the top bit set is illegal
    always_comb begin
        is_mv      = 1'b0;
        is_mvi     = 1'b0;
        is_alu     = 1'b0;
        is_illegal = 1'b0;
        ula_op     = ULA_ADD;
        case (op)
            OP_MV:  is_mv  = 1'b1;
            OP_MVI: is_mvi = 1'b1;
            OP_ADD: begin is_alu = 1'b1; ula_op = ULA_ADD; end
            OP_SUB: begin is_alu = 1'b1; ula_op = ULA_SUB; end
            OP_OR:  begin is_alu = 1'b1; ula_op = ULA_OR;  end
            OP_SLT: begin is_alu = 1'b1; ula_op = ULA_SLT; end
            OP_SLL: begin is_alu = 1'b1; ula_op = ULA_SLL; end
            OP_SRL: begin is_alu = 1'b1; ula_op = ULA_SRL; end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ula_sequencer.sv
// rtl/ula_sequencer.sv - multi-cycle ALU/bus sequencer; optional sticky illegal flag via ULA_SEQ_ILLEGAL_FLAG_EN
module ula_sequencer
    import ula_seq_pkg::*;
#(
    parameter int DATA_W = ULA_DATA_W,
    parameter int NREG   = ULA_NREG
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              IRin,
    output logic [NREG-1:0]   Rout,
    output logic              Gout,
    output logic              DINout,
    output logic [NREG-1:0]   Rin,
    output logic              Ain,
    output logic              Gin,
    output logic [2:0]        sinal_ULA,
    output logic              Done
`ifdef ULA_SEQ_ILLEGAL_FLAG_EN
    ,
    output logic              illegal
`endif
);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] ir;

    logic            is_mv;
    logic            is_mvi;
    logic            is_alu;
    logic            is_illegal;
    logic [2:0]      ula_op;
    logic [NREG-1:0] rx_oh;
    logic [NREG-1:0] ry_oh;

    ula_seq_decode #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_decode (
        .ir         (ir),
        .is_mv      (is_mv),
        .is_mvi     (is_mvi),
        .is_alu     (is_alu),
        .is_illegal (is_illegal),
        .ula_op     (ula_op),
        .rx_oh      (rx_oh),
        .ry_oh      (ry_oh)
    );

    // State register and instruction latch; IR only loads when a new instruction is accepted
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && Run) begin
                ir <= DIN;
            end
        end
    end

    // Next state and strobes; everything is forced low while reset is asserted
    always_comb begin
        next_state = state;
        IRin       = 1'b0;
        Rout       = '0;
        Gout       = 1'b0;
        DINout     = 1'b0;
        Rin        = '0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        sinal_ULA  = ULA_ADD;
        Done       = 1'b0;
        case (state)
            S_IDLE: begin
                IRin = Run;
                if (Run) begin
                    next_state = S_T1;
                end
            end
            S_T1: begin
                if (is_alu) begin
                    Rout       = rx_oh;
                    Ain        = 1'b1;
                    next_state = S_T2;
                end else begin
                    // mv, mvi and illegal opcodes all retire here
                    Done       = is_mv | is_mvi | is_illegal;
                    next_state = S_IDLE;
                    if (is_mv) begin
                        Rout = ry_oh;
                        Rin  = rx_oh;
                    end
                    if (is_mvi) begin
                        DINout = 1'b1;
                        Rin    = rx_oh;
                    end
                end
            end
            S_T2: begin
                Rout       = ry_oh;
                Gin        = 1'b1;
                sinal_ULA  = ula_op;
                next_state = S_T3;
            end
            S_T3: begin
                Gout       = 1'b1;
                Rin        = rx_oh;
                Done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        if (!Resetn) begin
            IRin      = 1'b0;
            Rout      = '0;
            Gout      = 1'b0;
            DINout    = 1'b0;
            Rin       = '0;
            Ain       = 1'b0;
            Gin       = 1'b0;
            sinal_ULA = ULA_ADD;
            Done      = 1'b0;
        end
    end

`ifdef ULA_SEQ_ILLEGAL_FLAG_EN
    logic illegal_q;

    // Sticky record that an illegal opcode has been executed since reset
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            illegal_q <= 1'b0;
        end else if (state == S_T1 && is_illegal) begin
            illegal_q <= 1'b1;
        end
    end

    // Flag is visible already in the retiring cycle, not one cycle later
    always_comb begin
        illegal = Resetn & (illegal_q | (state == S_T1 && is_illegal));
    end
`endif

endmodule
